// File: rtl/lcd_timing_pattern_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : lcd_timing_pattern_gen_if
//  Brief    : Control inputs, panel pins and coordinate outputs of the LCD
//             timing / test-pattern generator.
//  Revision : 1.0  initial release
// ============================================================================
interface lcd_timing_pattern_gen_if #(
  parameter int CNT_W = 12
);
  logic             Enable;
  logic [1:0]       Mode;
  logic [15:0]      SolidColor;
  logic [15:0]      BoxColor;
  logic [CNT_W-1:0] BoxLeft;
  logic [CNT_W-1:0] BoxRight;
  logic [CNT_W-1:0] BoxTop;
  logic [CNT_W-1:0] BoxBottom;
  logic             LCD_DE;
  logic             LCD_HSYNC;
  logic             LCD_VSYNC;
  logic [4:0]       LCD_R;
  logic [5:0]       LCD_G;
  logic [4:0]       LCD_B;
  logic [CNT_W-1:0] PixelX;
  logic [CNT_W-1:0] PixelY;
  logic             LineStart;
  logic             FrameStart;

  modport master (
    output Enable, Mode, SolidColor, BoxColor, BoxLeft, BoxRight, BoxTop, BoxBottom,
    input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B,
    input  PixelX, PixelY, LineStart, FrameStart
  );

  modport slave (
    input  Enable, Mode, SolidColor, BoxColor, BoxLeft, BoxRight, BoxTop, BoxBottom,
    output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B,
    output PixelX, PixelY, LineStart, FrameStart
  );
endinterface
`default_nettype wire

// File: rtl/lcd_timing_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : lcd_timing_pattern_gen
//  Brief    : Parametrised RGB565 parallel-LCD timing generator with
//             run-time selectable test pattern (solid, bars, box, checker).
//  Revision : 1.0  initial release
// ============================================================================
module lcd_timing_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_SYNC   = 1,
  parameter int H_BP     = 182,
  parameter int H_FP     = 210,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 0,
  parameter int V_FP     = 45,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12,
  parameter int CHK_LOG2 = 5
) (
  input  wire logic               PixelClk,
  input  wire logic               RST,
  lcd_timing_pattern_gen_if.slave bus
);

  localparam int c_H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int c_V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int c_BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_H_LAST  = CNT_W'(c_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_LAST  = CNT_W'(c_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_H_SYNC  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] c_V_SYNC  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] c_H_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] c_H_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_START = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] c_V_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic             c_HS_IDLE = ~HS_POL;
  localparam logic             c_VS_IDLE = ~VS_POL;

  if ((c_H_TOTAL - 1) >= (2 ** CNT_W) || (c_V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold H_TOTAL-1 / V_TOTAL-1");
  end

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic [1:0]       r_mode;
  logic [15:0]      r_solid;
  logic [15:0]      r_box_color;
  logic [CNT_W-1:0] r_box_left;
  logic [CNT_W-1:0] r_box_right;
  logic [CNT_W-1:0] r_box_top;
  logic [CNT_W-1:0] r_box_bottom;

  logic             r_de;
  logic             r_hs;
  logic             r_vs;
  logic [15:0]      r_rgb;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_ls;
  logic             r_fs;

  logic             w_frame_end;
  logic             w_x_act;
  logic             w_y_act;
  logic             w_de;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic [2:0]       w_bar_idx;
  logic [15:0]      w_bar_color;
  logic             w_in_box;
  logic [15:0]      w_rgb;

  assign w_frame_end = (r_h == c_H_LAST) && (r_v == c_V_LAST);

  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!bus.Enable) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == c_H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == c_V_LAST) ? '0 : r_v + c_ONE;
    end else begin
      r_h <= r_h + c_ONE;
    end
  end

  // Pattern controls only change between frames so a frame never tears.
  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      r_mode       <= '0;
      r_solid      <= '0;
      r_box_color  <= '0;
      r_box_left   <= '0;
      r_box_right  <= '0;
      r_box_top    <= '0;
      r_box_bottom <= '0;
    end else if (!bus.Enable || w_frame_end) begin
      r_mode       <= bus.Mode;
      r_solid      <= bus.SolidColor;
      r_box_color  <= bus.BoxColor;
      r_box_left   <= bus.BoxLeft;
      r_box_right  <= bus.BoxRight;
      r_box_top    <= bus.BoxTop;
      r_box_bottom <= bus.BoxBottom;
    end
  end

  assign w_x_act = (r_h >= c_H_START) && (r_h < c_H_END);
  assign w_y_act = (r_v >= c_V_START) && (r_v < c_V_END);
  assign w_de    = w_x_act && w_y_act;
  assign w_x     = w_de ? (r_h - c_H_START) : '0;
  assign w_y     = w_de ? (r_v - c_V_START) : '0;

  // Threshold count gives min(x / BAR_W, 7) without a divider.
  always_comb begin
    w_bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (w_x >= CNT_W'(k * c_BAR_W)) w_bar_idx = 3'(k);
    end
  end

  always_comb begin
    w_bar_color = 16'h0000;
    case (w_bar_idx)
      3'd0:    w_bar_color = 16'hFFFF;
      3'd1:    w_bar_color = 16'hFFE0;
      3'd2:    w_bar_color = 16'h07FF;
      3'd3:    w_bar_color = 16'h07E0;
      3'd4:    w_bar_color = 16'hF81F;
      3'd5:    w_bar_color = 16'hF800;
      3'd6:    w_bar_color = 16'h001F;
      default: w_bar_color = 16'h0000;
    endcase
  end

  assign w_in_box = (r_box_left <= w_x) && (w_x <= r_box_right) &&
                    (r_box_top  <= w_y) && (w_y <= r_box_bottom);

  always_comb begin
    w_rgb = 16'h0000;
    if (w_de) begin
      case (r_mode)
        2'd0:    w_rgb = r_solid;
        2'd1:    w_rgb = w_bar_color;
        2'd2:    w_rgb = w_in_box ? r_box_color : r_solid;
        default: w_rgb = (w_x[CHK_LOG2] ^ w_y[CHK_LOG2]) ? r_box_color : r_solid;
      endcase
    end
  end

  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST || !bus.Enable) begin
      r_de  <= 1'b0;
      r_hs  <= c_HS_IDLE;
      r_vs  <= c_VS_IDLE;
      r_rgb <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_de  <= w_de;
      r_hs  <= (r_h < c_H_SYNC) ? HS_POL : c_HS_IDLE;
      r_vs  <= (r_v < c_V_SYNC) ? VS_POL : c_VS_IDLE;
      r_rgb <= w_rgb;
      r_x   <= w_x;
      r_y   <= w_y;
      r_ls  <= (r_h == '0);
      r_fs  <= (r_h == '0) && (r_v == '0);
    end
  end

  assign bus.LCD_DE     = r_de;
  assign bus.LCD_HSYNC  = r_hs;
  assign bus.LCD_VSYNC  = r_vs;
  assign bus.LCD_R      = r_rgb[15:11];
  assign bus.LCD_G      = r_rgb[10:5];
  assign bus.LCD_B      = r_rgb[4:0];
  assign bus.PixelX     = r_x;
  assign bus.PixelY     = r_y;
  assign bus.LineStart  = r_ls;
  assign bus.FrameStart = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lcd_timing_pattern_gen
//  Brief    : Self-checking bench for lcd_timing_pattern_gen on a small raster.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lcd_timing_pattern_gen;

  localparam int HA = 64, HS = 2, HBP = 5, HFP = 4;
  localparam int VA = 24, VS = 2, VBP = 1, VFP = 3;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int CW = 12;
  localparam int CHK = 3;
  localparam int BW = HA / 8;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;

  logic PixelClk = 1'b0;
  logic RST = 1'b1;
  always #5 PixelClk = ~PixelClk;

  lcd_timing_pattern_gen_if #(.CNT_W(CW)) bus ();

  lcd_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_FP(HFP),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP),
    .HS_POL(HSP), .VS_POL(VSP), .CNT_W(CW), .CHK_LOG2(CHK)
  ) dut (
    .PixelClk(PixelClk),
    .RST(RST),
    .bus(bus)
  );

  // {de, hs, vs, rgb[15:0], x[11:0], y[11:0], ls, fs}
  wire [44:0] dut_vec = {bus.LCD_DE, bus.LCD_HSYNC, bus.LCD_VSYNC,
                         bus.LCD_R, bus.LCD_G, bus.LCD_B,
                         bus.PixelX, bus.PixelY, bus.LineStart, bus.FrameStart};

  int n_chk = 0;
  int n_fail = 0;
  logic [44:0] exp_cur;
  logic [44:0] exp_q[$];

  int m_h = 0, m_v = 0;
  logic [1:0]  m_mode = '0;
  logic [15:0] m_sc = '0, m_bc = '0;
  int m_bl = 0, m_br = 0, m_bt = 0, m_bb = 0;

  function automatic logic [44:0] idle_vec();
    return {1'b0, ~HSP, ~VSP, 16'h0, 12'h0, 12'h0, 1'b0, 1'b0};
  endfunction

  function automatic logic [15:0] bar_color(int idx);
    logic [15:0] tbl [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return tbl[idx];
  endfunction

  function automatic logic [44:0] model_out(int h, int v);
    bit de, hs_o, vs_o;
    int x, y, idx;
    logic [15:0] rgb;
    de   = (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
    hs_o = (h < HS) ? HSP : ~HSP;
    vs_o = (v < VS) ? VSP : ~VSP;
    x    = de ? h - (HS + HBP) : 0;
    y    = de ? v - (VS + VBP) : 0;
    rgb  = 16'h0;
    if (de) begin
      case (m_mode)
        2'd0: rgb = m_sc;
        2'd1: begin idx = x / BW; if (idx > 7) idx = 7; rgb = bar_color(idx); end
        2'd2: rgb = (m_bl <= x && x <= m_br && m_bt <= y && y <= m_bb) ? m_bc : m_sc;
        default: rgb = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? m_bc : m_sc;
      endcase
    end
    return {de, hs_o, vs_o, rgb, 12'(x), 12'(y), (h == 0), (h == 0 && v == 0)};
  endfunction

  // Reference model: predicts each registered output at the edge it is produced.
  always @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      m_h = 0; m_v = 0; m_mode = '0; m_sc = '0; m_bc = '0;
      m_bl = 0; m_br = 0; m_bt = 0; m_bb = 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(bus.Enable ? model_out(m_h, m_v) : idle_vec());
      if (!bus.Enable || (m_h == HT - 1 && m_v == VT - 1)) begin
        m_mode = bus.Mode; m_sc = bus.SolidColor; m_bc = bus.BoxColor;
        m_bl = int'(bus.BoxLeft); m_br = int'(bus.BoxRight);
        m_bt = int'(bus.BoxTop);  m_bb = int'(bus.BoxBottom);
      end
      if (!bus.Enable) begin
        m_h = 0; m_v = 0;
      end else begin
        m_h++;
        if (m_h == HT) begin
          m_h = 0; m_v++;
          if (m_v == VT) m_v = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge PixelClk);
    exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_vec();
  endtask

  task automatic set_cfg(logic [1:0] md, logic [15:0] sc, logic [15:0] bc,
                         int l, int r, int t, int b);
    bus.Mode = md; bus.SolidColor = sc; bus.BoxColor = bc;
    bus.BoxLeft = 12'(l); bus.BoxRight = 12'(r); bus.BoxTop = 12'(t); bus.BoxBottom = 12'(b);
  endtask

  task automatic restart(logic [1:0] md, logic [15:0] sc, logic [15:0] bc,
                         int l, int r, int t, int b);
    bus.Enable = 1'b0;
    set_cfg(md, sc, bc, l, r, t, b);
    tick();
    bus.Enable = 1'b1;
  endtask

  task automatic test_reset();
    bus.Enable = 1'b0;
    set_cfg(2'd0, 16'h0, 16'h0, 0, 0, 0, 0);
    tick(); tick();
    n_chk++;
    if (dut_vec !== idle_vec()) begin
      n_fail++; $display("FAIL reset_state got %h want %h", dut_vec, idle_vec());
    end
    bus.Enable = 1'b1;
    tick(); tick();
    n_chk++;
    if (dut_vec !== idle_vec()) begin
      n_fail++; $display("FAIL reset_held_enabled got %h want %h", dut_vec, idle_vec());
    end
    bus.Enable = 1'b0;
    #2 RST = 1'b0;
    tick();
  endtask

  task automatic test_timing();
    int de_tot = 0, hs_tot = 0, vs_tot = 0, ls_tot = 0, fs_tot = 0, de_lines = 0, run = 0, max_run = 0;
    bit prev_de = 0;
    set_cfg(2'd0, 16'hA5C3, 16'h0, 0, 0, 0, 0);
    bus.Enable = 1'b1;
    for (int c = 0; c <= HT * VT; c++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_cur) begin
        n_fail++; $display("FAIL timing_cycle c=%0d got %h want %h", c, dut_vec, exp_cur);
      end
      if (c < HT * VT) begin
        de_tot += dut_vec[44];
        hs_tot += (dut_vec[43] == HSP);
        vs_tot += (dut_vec[42] == VSP);
        ls_tot += dut_vec[1];
        fs_tot += dut_vec[0];
        if (dut_vec[44] && !prev_de) de_lines++;
        run = dut_vec[44] ? run + 1 : 0;
        if (run > max_run) max_run = run;
        prev_de = dut_vec[44];
      end
    end
    n_chk++; if (dut_vec[0] !== 1'b1) begin n_fail++; $display("FAIL frame_period fs got %b want 1 at %0d", dut_vec[0], HT * VT); end
    n_chk++; if (fs_tot != 1) begin n_fail++; $display("FAIL frame_start_count got %0d want 1", fs_tot); end
    n_chk++; if (de_tot != HA * VA) begin n_fail++; $display("FAIL de_total got %0d want %0d", de_tot, HA * VA); end
    n_chk++; if (max_run != HA) begin n_fail++; $display("FAIL de_per_line got %0d want %0d", max_run, HA); end
    n_chk++; if (de_lines != VA) begin n_fail++; $display("FAIL de_lines got %0d want %0d", de_lines, VA); end
    n_chk++; if (hs_tot != HS * VT) begin n_fail++; $display("FAIL hsync_active got %0d want %0d", hs_tot, HS * VT); end
    n_chk++; if (vs_tot != VS * HT) begin n_fail++; $display("FAIL vsync_active got %0d want %0d", vs_tot, VS * HT); end
    n_chk++; if (ls_tot != VT) begin n_fail++; $display("FAIL line_starts got %0d want %0d", ls_tot, VT); end
  endtask

  task automatic test_bars();
    restart(2'd1, 16'h0, 16'h0, 0, 0, 0, 0);
    for (int c = 0; c < HT * VT; c++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_cur) begin
        n_fail++; $display("FAIL bars_cycle c=%0d got %h want %h", c, dut_vec, exp_cur);
      end
      if (dut_vec[44] && dut_vec[13:2] == 12'd0) begin
        if (dut_vec[25:14] == 12'd0) begin
          n_chk++; if (dut_vec[41:26] !== 16'hFFFF) begin n_fail++; $display("FAIL bar_x0 got %h want FFFF", dut_vec[41:26]); end
        end
        if (dut_vec[25:14] == 12'(BW + 4)) begin
          n_chk++; if (dut_vec[41:26] !== 16'hFFE0) begin n_fail++; $display("FAIL bar_1 got %h want FFE0", dut_vec[41:26]); end
        end
        if (dut_vec[25:14] == 12'(HA - 1)) begin
          n_chk++; if (dut_vec[41:26] !== 16'h0000) begin n_fail++; $display("FAIL bar_7 got %h want 0000", dut_vec[41:26]); end
        end
      end
    end
  endtask

  task automatic test_box();
    int nz = 0;
    restart(2'd2, 16'h0000, 16'h07E0, 10, 20, 10, 20);
    for (int c = 0; c < HT * VT; c++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_cur) begin
        n_fail++; $display("FAIL box_cycle c=%0d got %h want %h", c, dut_vec, exp_cur);
      end
      if (dut_vec[44] && dut_vec[25:14] == 12'd10 && dut_vec[13:2] == 12'd10) begin
        n_chk++; if (dut_vec[41:26] !== 16'h07E0) begin n_fail++; $display("FAIL box_corner_tl got %h want 07E0", dut_vec[41:26]); end
      end
      if (dut_vec[44] && dut_vec[25:14] == 12'd20 && dut_vec[13:2] == 12'd20) begin
        n_chk++; if (dut_vec[41:26] !== 16'h07E0) begin n_fail++; $display("FAIL box_corner_br got %h want 07E0", dut_vec[41:26]); end
      end
      if (dut_vec[44] && dut_vec[25:14] == 12'd21 && dut_vec[13:2] == 12'd10) begin
        n_chk++; if (dut_vec[41:26] !== 16'h0000) begin n_fail++; $display("FAIL box_outside got %h want 0000", dut_vec[41:26]); end
      end
    end
    restart(2'd2, 16'h0000, 16'h07E0, 20, 10, 20, 10);
    for (int c = 0; c < HT * VT; c++) begin
      tick();
      if (dut_vec[41:26] != 16'h0) nz++;
    end
    n_chk++; if (nz != 0) begin n_fail++; $display("FAIL box_inverted nonzero_pixels got %0d want 0", nz); end
  endtask

  task automatic test_checker();
    restart(2'd3, 16'h001F, 16'hF800, 0, 0, 0, 0);
    for (int c = 0; c < HT * VT; c++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_cur) begin
        n_fail++; $display("FAIL checker_cycle c=%0d got %h want %h", c, dut_vec, exp_cur);
      end
      if (dut_vec[44] && dut_vec[25:14] == 12'd8 && dut_vec[13:2] == 12'd0) begin
        n_chk++; if (dut_vec[41:26] !== 16'hF800) begin n_fail++; $display("FAIL checker_on got %h want F800", dut_vec[41:26]); end
      end
      if (dut_vec[44] && dut_vec[25:14] == 12'd8 && dut_vec[13:2] == 12'd8) begin
        n_chk++; if (dut_vec[41:26] !== 16'h001F) begin n_fail++; $display("FAIL checker_off got %h want 001F", dut_vec[41:26]); end
      end
    end
  endtask

  task automatic test_shadow();
    int bad = 0, guard = 0;
    bit seen_fs = 0, got = 0;
    restart(2'd0, 16'h1234, 16'h0, 0, 0, 0, 0);
    while (!(dut_vec[44] && dut_vec[13:2] == 12'd10) && guard < 2 * HT * VT) begin tick(); guard++; end
    bus.Mode = 2'd1;
    guard = 0;
    while (!seen_fs && guard < 2 * HT * VT) begin
      tick(); guard++;
      n_chk++;
      if (dut_vec !== exp_cur) begin
        n_fail++; $display("FAIL shadow_cycle got %h want %h", dut_vec, exp_cur);
      end
      if (dut_vec[0]) seen_fs = 1;
      else if (dut_vec[44] && dut_vec[41:26] != 16'h1234) bad++;
    end
    n_chk++; if (!seen_fs) begin n_fail++; $display("FAIL shadow_wait_fs got timeout want FrameStart"); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL shadow_no_tear torn_pixels got %0d want 0", bad); end
    guard = 0;
    while (!got && guard < 2 * HT * VT) begin
      tick(); guard++;
      if (dut_vec[44]) got = 1;
    end
    n_chk++;
    if (!got || dut_vec[41:26] !== 16'hFFFF) begin
      n_fail++; $display("FAIL shadow_first_bar got %h (de_seen=%0d) want FFFF", dut_vec[41:26], got);
    end
  endtask

  task automatic test_enable_drop();
    int guard = 0, cnt = 0;
    bit got = 0;
    while (!(dut_vec[44] && dut_vec[25:14] == 12'd30) && guard < 2 * HT * VT) begin tick(); guard++; end
    bus.Enable = 1'b0;
    tick();
    n_chk++;
    if (dut_vec !== idle_vec()) begin
      n_fail++; $display("FAIL enable_drop got %h want %h", dut_vec, idle_vec());
    end
    bus.Enable = 1'b1;
    tick();
    n_chk++;
    if (dut_vec !== exp_cur || dut_vec[0] !== 1'b1) begin
      n_fail++; $display("FAIL enable_rise_fs got %h want %h", dut_vec, exp_cur);
    end
    while (!got && cnt < 2 * HT * VT) begin
      tick(); cnt++;
      if (dut_vec[44]) got = 1;
    end
    n_chk++;
    if (!got || cnt != (VS + VBP) * HT + HS + HBP) begin
      n_fail++; $display("FAIL first_de_latency got %0d want %0d", cnt, (VS + VBP) * HT + HS + HBP);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!(dut_vec[44] && dut_vec[25:14] == 12'd20) && guard < 2 * HT * VT) begin tick(); guard++; end
    #2 RST = 1'b1;
    #1;
    n_chk++;
    if (dut_vec !== idle_vec()) begin
      n_fail++; $display("FAIL async_reset got %h want %h", dut_vec, idle_vec());
    end
    tick();
    #2 RST = 1'b0;
    tick();
    n_chk++;
    if (dut_vec !== exp_cur || dut_vec[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_fs got %h want %h", dut_vec, exp_cur);
    end
    for (int c = 0; c < 3 * HT; c++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_cur) begin
        n_fail++; $display("FAIL post_reset_cycle c=%0d got %h want %h", c, dut_vec, exp_cur);
      end
    end
  endtask

  initial begin
    bus.Enable = 1'b0;
    set_cfg(2'd0, 16'h0, 16'h0, 0, 0, 0, 0);
    exp_cur = idle_vec();
    test_reset();
    test_timing();
    test_bars();
    test_box();
    test_checker();
    test_shadow();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
